ofmap_accum_serializer: RTL and testbench
=========================================

OFMAP_ACCUM_SERIALIZER -- requirements
Module: ofmap_accum_serializer

Interface
REQ-001 SHALL have parameter OFMAP_WIDTH, default 32: width of one output pixel, two's-complement.
REQ-002 SHALL have parameter ARRAY_WIDTH, default 4: psum lanes per beat, equal to OC0.
REQ-003 SHALL have parameter MAX_PIXELS, default 64: accumulator depth in OX0*OY0 pixel entries.
REQ-004 SHALL have parameter COUNT_WIDTH, default 16: width of the configuration counters.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port cfg_vld, input, 1 bit: configuration valid.
REQ-008 SHALL have port cfg_rdy, output, 1 bit: configuration accepted.
REQ-009 SHALL have port cfg_num_passes, input, COUNT_WIDTH bits: accumulation passes per tile (IC1*FY*FX).
REQ-010 SHALL have port cfg_num_pixels, input, COUNT_WIDTH bits: pixels per tile (OX0*OY0).
REQ-011 SHALL have port psum_vld, input, 1 bit: psum beat valid.
REQ-012 SHALL have port psum_rdy, output, 1 bit: psum beat accepted.
REQ-013 SHALL have port psum_dat, input, OFMAP_WIDTH*ARRAY_WIDTH bits: one psum per lane, lane 0 in the LSBs.
REQ-014 SHALL have port ofmap_dat, output, OFMAP_WIDTH bits: serialized output pixel.
REQ-015 SHALL have port ofmap_vld, output, 1 bit: output valid.
REQ-016 SHALL have port ofmap_rdy, input, 1 bit: downstream ready.

Function
REQ-017 SHALL implement an FSM with states IDLE, ACCUM and DRAIN.
REQ-018 SHALL assert cfg_rdy only in IDLE and latch both cfg fields when cfg_vld && cfg_rdy, then enter ACCUM on the next cycle.
REQ-019 SHALL treat a latched cfg value of 0 as 1, and a cfg_num_pixels value above MAX_PIXELS as MAX_PIXELS.
REQ-020 SHALL assert psum_rdy only in ACCUM; a transfer occurs on psum_vld && psum_rdy.
REQ-021 SHALL, on each transfer, use entry = pixel_cnt; on pass 0 write psum_dat into the entry, on later passes add psum_dat lane-wise to the entry.
REQ-022 SHALL perform the addition modulo 2^OFMAP_WIDTH with no saturation.
REQ-023 SHALL wrap pixel_cnt at num_pixels-1 to 0 and increment pass_cnt on that wrap.
REQ-024 SHALL, on the transfer with pixel_cnt==num_pixels-1 and pass_cnt==num_passes-1, enter DRAIN on the next cycle; psum_rdy is low in that next cycle.
REQ-025 SHALL, in DRAIN, present words in the order pixel 0 lane 0, pixel 0 lane 1, ..., pixel N-1 lane ARRAY_WIDTH-1; total num_pixels*ARRAY_WIDTH words.
REQ-026 SHALL assert ofmap_vld on the first DRAIN cycle; first-word latency is 1 cycle after the final psum transfer.
REQ-027 SHALL hold ofmap_dat and ofmap_vld stable while ofmap_vld && !ofmap_rdy; a word advances only on ofmap_vld && ofmap_rdy.
REQ-028 SHALL sustain 1 word/cycle while ofmap_rdy stays high.
REQ-029 SHALL return to IDLE the cycle after the last word is accepted, with ofmap_vld low in that cycle.
REQ-030 SHALL ignore cfg_vld outside IDLE and ignore psum_vld outside ACCUM; neither has any side effect.

Reset
REQ-031 SHALL, on rst high at a clock edge, enter IDLE with cfg_rdy=1 (IDLE behaviour), psum_rdy=0, ofmap_vld=0 and ofmap_dat=0.
REQ-032 SHALL, on rst high at a clock edge, clear pixel_cnt, pass_cnt and drain_cnt; accumulator contents need not be cleared.
REQ-033 SHALL abandon an in-progress tile when reset occurs in any state; the next tile requires a new configuration.

Configuration
REQ-034 SHALL, when macro OFMAP_RELU_EN is defined, replace any drained word with MSB=1 by 0 (ReLU on drain only); accumulation is unaffected.
REQ-035 SHALL, when OFMAP_RELU_EN is undefined, drain raw signed accumulator values.

Structure
REQ-036 SHALL place the FSM state enum (IDLE/ACCUM/DRAIN) and the default widths OFMAP_WIDTH and COUNT_WIDTH in shared package conv_pkg.
REQ-037 SHALL implement the accumulator storage as sub-module psum_accum_bank: MAX_PIXELS x (OFMAP_WIDTH*ARRAY_WIDTH), one read/modify/write port.

Verification
REQ-038 SHALL cover: cfg passes=1, pixels=2; psum beats {1,2,3,4} then {5,6,7,8} -> output 1,2,3,4,5,6,7,8 with ofmap_rdy always high.
REQ-039 SHALL cover: passes=3, pixels=1; each beat lanes={10,-1,0x7FFFFFFF,5} -> output 30, -3, 0x7FFFFFFD (wraparound), 15.
REQ-040 SHALL cover: ofmap_rdy toggled 1010... during drain -> each word held stable, no loss or duplication, 8 words total.
REQ-041 SHALL cover: cfg_vld during ACCUM with differing values -> ignored; results match the original configuration.
REQ-042 SHALL cover: rst pulsed mid-DRAIN -> next cycle ofmap_vld=0, cfg_rdy=1; a fresh tile completes correctly.
REQ-043 SHALL cover, with OFMAP_RELU_EN defined: a lane accumulating to -7 -> drains as 0, and a positive lane is unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and default widths for the ofmap accumulation path.
package conv_pkg;

  localparam int unsigned OFMAP_WIDTH = 32;
  localparam int unsigned COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Index width that stays legal for single-entry structures.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_accum_bank.sv
// Pixel-indexed psum accumulator: one read/modify/write port plus a drain read
// port that forwards the value being written when both hit the same entry.
module psum_accum_bank #(
  parameter int unsigned OFMAP_WIDTH = 32,
  parameter int unsigned ARRAY_WIDTH = 4,
  parameter int unsigned MAX_PIXELS  = 64,
  parameter int unsigned ADDR_WIDTH  = (MAX_PIXELS > 1) ? $clog2(MAX_PIXELS) : 1
) (
  input  logic                               clk,
  input  logic                               i_we,
  input  logic                               i_first,
  input  logic [ADDR_WIDTH-1:0]              i_addr,
  input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] i_psum,
  input  logic [ADDR_WIDTH-1:0]              i_rd_addr,
  output logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] o_rd_data_c
);

  localparam int unsigned DW = OFMAP_WIDTH * ARRAY_WIDTH;

  logic [DW-1:0] r_mem [MAX_PIXELS];
  logic [DW-1:0] w_old;
  logic [DW-1:0] w_new;

  assign w_old = r_mem[i_addr];

  // Lane-wise overwrite on the first pass, wrapping add afterwards.
  for (genvar l = 0; l < ARRAY_WIDTH; l++) begin : g_lane
    assign w_new[l*OFMAP_WIDTH +: OFMAP_WIDTH] = i_first
        ? i_psum[l*OFMAP_WIDTH +: OFMAP_WIDTH]
        : w_old[l*OFMAP_WIDTH +: OFMAP_WIDTH] + i_psum[l*OFMAP_WIDTH +: OFMAP_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= w_new;
    end
  end

  assign o_rd_data_c = (i_we && (i_rd_addr == i_addr)) ? w_new : r_mem[i_rd_addr];

endmodule

// File: rtl/ofmap_accum_serializer.sv
// Accumulates psum beats over a tile, then serializes pixels lane by lane.
// Define OFMAP_RELU_EN to clamp negative drained words to zero.
module ofmap_accum_serializer #(
  parameter int unsigned OFMAP_WIDTH = conv_pkg::OFMAP_WIDTH,
  parameter int unsigned ARRAY_WIDTH = 4,
  parameter int unsigned MAX_PIXELS  = 64,
  parameter int unsigned COUNT_WIDTH = conv_pkg::COUNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_vld,
  output logic                               cfg_rdy,
  input  logic [COUNT_WIDTH-1:0]             cfg_num_passes,
  input  logic [COUNT_WIDTH-1:0]             cfg_num_pixels,
  input  logic                               psum_vld,
  output logic                               psum_rdy,
  input  logic [OFMAP_WIDTH*ARRAY_WIDTH-1:0] psum_dat,
  output logic [OFMAP_WIDTH-1:0]             ofmap_dat,
  output logic                               ofmap_vld,
  input  logic                               ofmap_rdy
);

  import conv_pkg::*;

  localparam int unsigned DW         = OFMAP_WIDTH * ARRAY_WIDTH;
  localparam int unsigned ADDR_WIDTH = idx_width(MAX_PIXELS);
  localparam int unsigned LANE_WIDTH = idx_width(ARRAY_WIDTH);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_cfg_rdy;
  logic                    r_psum_rdy;
  logic                    r_ofmap_vld;
  logic [OFMAP_WIDTH-1:0]  r_ofmap_dat;
  logic [COUNT_WIDTH-1:0]  r_num_passes;
  logic [COUNT_WIDTH-1:0]  r_num_pixels;
  logic [COUNT_WIDTH-1:0]  r_pixel_cnt;
  logic [COUNT_WIDTH-1:0]  r_pass_cnt;
  logic [COUNT_WIDTH-1:0]  r_drain_pix;
  logic [LANE_WIDTH-1:0]   r_drain_lane;

  logic                    w_cfg_fire;
  logic                    w_psum_fire;
  logic                    w_ofmap_fire;
  logic                    w_last_pix;
  logic                    w_last_pass;
  logic                    w_lane_wrap;
  logic                    w_last_word;
  logic                    w_load;
  logic [COUNT_WIDTH-1:0]  w_cfg_passes;
  logic [COUNT_WIDTH-1:0]  w_cfg_pixels;
  logic [COUNT_WIDTH-1:0]  w_nxt_pix;
  logic [LANE_WIDTH-1:0]   w_nxt_lane;
  logic [COUNT_WIDTH-1:0]  w_rd_pix;
  logic [LANE_WIDTH-1:0]   w_rd_lane;
  logic [DW-1:0]           w_rd_data;
  logic [OFMAP_WIDTH-1:0]  w_lanes [ARRAY_WIDTH];
  logic [OFMAP_WIDTH-1:0]  w_word;
  logic [OFMAP_WIDTH-1:0]  w_word_out;

  assign cfg_rdy   = r_cfg_rdy;
  assign psum_rdy  = r_psum_rdy;
  assign ofmap_vld = r_ofmap_vld;
  assign ofmap_dat = r_ofmap_dat;

  assign w_cfg_fire   = cfg_vld && r_cfg_rdy;
  assign w_psum_fire  = psum_vld && r_psum_rdy;
  assign w_ofmap_fire = r_ofmap_vld && ofmap_rdy;
  assign w_last_pix   = (r_pixel_cnt == r_num_pixels - COUNT_WIDTH'(1));
  assign w_last_pass  = (r_pass_cnt == r_num_passes - COUNT_WIDTH'(1));
  assign w_lane_wrap  = (r_drain_lane == LANE_WIDTH'(ARRAY_WIDTH - 1));
  assign w_last_word  = w_lane_wrap && (r_drain_pix == r_num_pixels - COUNT_WIDTH'(1));

  // Zero counts mean one; pixel counts saturate at the bank depth.
  assign w_cfg_passes = (cfg_num_passes == '0) ? COUNT_WIDTH'(1) : cfg_num_passes;
  assign w_cfg_pixels = (cfg_num_pixels == '0) ? COUNT_WIDTH'(1)
                      : (cfg_num_pixels > COUNT_WIDTH'(MAX_PIXELS)) ? COUNT_WIDTH'(MAX_PIXELS)
                      : cfg_num_pixels;

  assign w_nxt_lane = w_lane_wrap ? '0 : r_drain_lane + LANE_WIDTH'(1);
  assign w_nxt_pix  = w_lane_wrap ? r_drain_pix + COUNT_WIDTH'(1) : r_drain_pix;

  // Word loaded at the final psum transfer is always pixel 0 lane 0.
  assign w_rd_pix  = (r_state == DRAIN) ? w_nxt_pix : '0;
  assign w_rd_lane = (r_state == DRAIN) ? w_nxt_lane : '0;

  psum_accum_bank #(
    .OFMAP_WIDTH (OFMAP_WIDTH),
    .ARRAY_WIDTH (ARRAY_WIDTH),
    .MAX_PIXELS  (MAX_PIXELS),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_bank (
    .clk         (clk),
    .i_we        (w_psum_fire),
    .i_first     (r_pass_cnt == '0),
    .i_addr      (ADDR_WIDTH'(r_pixel_cnt)),
    .i_psum      (psum_dat),
    .i_rd_addr   (ADDR_WIDTH'(w_rd_pix)),
    .o_rd_data_c (w_rd_data)
  );

  for (genvar l = 0; l < ARRAY_WIDTH; l++) begin : g_lane_sel
    assign w_lanes[l] = w_rd_data[l*OFMAP_WIDTH +: OFMAP_WIDTH];
  end

  assign w_word = w_lanes[w_rd_lane];

`ifdef OFMAP_RELU_EN
  assign w_word_out = w_word[OFMAP_WIDTH-1] ? '0 : w_word;
`else
  assign w_word_out = w_word;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cfg_fire) begin
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (w_psum_fire && w_last_pix && w_last_pass) begin
          w_state_nxt = DRAIN;
          w_load      = 1'b1;
        end
      end
      DRAIN: begin
        if (w_ofmap_fire) begin
          if (w_last_word) begin
            w_state_nxt = IDLE;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_rdy    <= 1'b1;
      r_psum_rdy   <= 1'b0;
      r_ofmap_vld  <= 1'b0;
      r_ofmap_dat  <= '0;
      r_num_passes <= COUNT_WIDTH'(1);
      r_num_pixels <= COUNT_WIDTH'(1);
      r_pixel_cnt  <= '0;
      r_pass_cnt   <= '0;
      r_drain_pix  <= '0;
      r_drain_lane <= '0;
    end else begin
      r_cfg_rdy   <= (w_state_nxt == IDLE);
      r_psum_rdy  <= (w_state_nxt == ACCUM);
      r_ofmap_vld <= (w_state_nxt == DRAIN);
      if (w_load) begin
        r_ofmap_dat <= w_word_out;
      end
      if (w_cfg_fire) begin
        r_num_passes <= w_cfg_passes;
        r_num_pixels <= w_cfg_pixels;
        r_pixel_cnt  <= '0;
        r_pass_cnt   <= '0;
        r_drain_pix  <= '0;
        r_drain_lane <= '0;
      end
      if (w_psum_fire) begin
        if (w_last_pix) begin
          r_pixel_cnt <= '0;
          r_pass_cnt  <= w_last_pass ? '0 : r_pass_cnt + COUNT_WIDTH'(1);
        end else begin
          r_pixel_cnt <= r_pixel_cnt + COUNT_WIDTH'(1);
        end
      end
      if (w_ofmap_fire) begin
        r_drain_pix  <= w_last_word ? '0 : w_nxt_pix;
        r_drain_lane <= w_last_word ? '0 : w_nxt_lane;
      end
    end
  end

endmodule

// File: tb/tb_ofmap_accum_serializer.sv
// Scoreboard bench for ofmap_accum_serializer: directed tiles with hand-computed words.
module tb_ofmap_accum_serializer;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned MP = 64;
  localparam int unsigned CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_vld;
  logic            cfg_rdy;
  logic [CW-1:0]   cfg_num_passes;
  logic [CW-1:0]   cfg_num_pixels;
  logic            psum_vld;
  logic            psum_rdy;
  logic [W*AW-1:0] psum_dat;
  logic [W-1:0]    ofmap_dat;
  logic            ofmap_vld;
  logic            ofmap_rdy;

  logic [W-1:0]    exp_q [$];
  int              n_checks = 0;
  int              n_errors = 0;
  logic            hold = 1'b0;
  logic [W-1:0]    held = '0;

  always #5 clk = ~clk;

  ofmap_accum_serializer #(
    .OFMAP_WIDTH (W),
    .ARRAY_WIDTH (AW),
    .MAX_PIXELS  (MP),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_vld        (cfg_vld),
    .cfg_rdy        (cfg_rdy),
    .cfg_num_passes (cfg_num_passes),
    .cfg_num_pixels (cfg_num_pixels),
    .psum_vld       (psum_vld),
    .psum_rdy       (psum_rdy),
    .psum_dat       (psum_dat),
    .ofmap_dat      (ofmap_dat),
    .ofmap_vld      (ofmap_vld),
    .ofmap_rdy      (ofmap_rdy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W*AW-1:0] pk(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic push4(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  // Monitor: pops on every accepted word and checks hold stability under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_vld", 64'(ofmap_vld), 64'd1);
        chk("hold_dat", 64'(ofmap_dat), 64'(held));
      end
      if (ofmap_vld && ofmap_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_word: got 0x%0h expected none", ofmap_dat);
        end else begin
          chk("ofmap_word", 64'(ofmap_dat), 64'(exp_q.pop_front()));
        end
      end
      hold = ofmap_vld && !ofmap_rdy;
      held = ofmap_dat;
    end
  end

  task automatic send_cfg(input int passes, input int pixels);
    logic got = 1'b0;
    cfg_num_passes = CW'(passes);
    cfg_num_pixels = CW'(pixels);
    cfg_vld = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = cfg_rdy;
      @(posedge clk);
      #1;
    end
    cfg_vld = 1'b0;
    chk("cfg_accepted", 64'(got), 64'd1);
  endtask

  task automatic send_beat(input logic [W*AW-1:0] d, input bit last);
    logic got = 1'b0;
    psum_dat = d;
    psum_vld = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = psum_rdy;
      @(posedge clk);
      #1;
    end
    psum_vld = 1'b0;
    chk("beat_accepted", 64'(got), 64'd1);
    if (last) begin
      chk("first_word_vld", 64'(ofmap_vld), 64'd1);
      chk("psum_rdy_after_last", 64'(psum_rdy), 64'd0);
    end
  endtask

  task automatic drain(input bit toggle, input int n);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 4 * n + 20) begin
      ofmap_rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    ofmap_rdy = 1'b1;
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    chk("drain_cycles", 64'(cyc), toggle ? 64'(2 * n - 1) : 64'(n));
    chk("end_vld_low", 64'(ofmap_vld), 64'd0);
    chk("end_cfg_rdy", 64'(cfg_rdy), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    cfg_vld = 1'b0;
    cfg_num_passes = '0;
    cfg_num_pixels = '0;
    psum_vld = 1'b0;
    psum_dat = '0;
    ofmap_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
    chk("rst_psum_rdy", 64'(psum_rdy), 64'd0);
    chk("rst_ofmap_vld", 64'(ofmap_vld), 64'd0);
    chk("rst_ofmap_dat", 64'(ofmap_dat), 64'd0);

    // Single pass, two pixels, full throughput.
    send_cfg(1, 2);
    push4(1, 2, 3, 4);
    push4(5, 6, 7, 8);
    send_beat(pk(1, 2, 3, 4), 1'b0);
    send_beat(pk(5, 6, 7, 8), 1'b1);
    drain(1'b0, 8);

    // Three passes on one pixel, including 32-bit wraparound.
    send_cfg(3, 1);
    push4(32'd30, 32'hFFFF_FFFD, 32'h7FFF_FFFD, 32'd15);
    send_beat(pk(10, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 5), 1'b0);
    send_beat(pk(10, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 5), 1'b0);
    send_beat(pk(10, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 5), 1'b1);
    drain(1'b0, 4);

    // Two passes, two pixels, drained under alternating backpressure.
    send_cfg(2, 2);
    push4(101, 202, 303, 404);
    push4(1010, 2020, 3030, 4040);
    send_beat(pk(1, 2, 3, 4), 1'b0);
    send_beat(pk(10, 20, 30, 40), 1'b0);
    send_beat(pk(100, 200, 300, 400), 1'b0);
    send_beat(pk(1000, 2000, 3000, 4000), 1'b1);
    drain(1'b1, 8);

    // New configuration offered mid-accumulation must be ignored.
    send_cfg(1, 2);
    push4(9, 8, 7, 6);
    push4(50, 60, 70, 80);
    send_beat(pk(9, 8, 7, 6), 1'b0);
    cfg_num_passes = CW'(5);
    cfg_num_pixels = CW'(3);
    cfg_vld = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("cfg_rdy_in_accum", 64'(cfg_rdy), 64'd0);
    end
    send_beat(pk(50, 60, 70, 80), 1'b1);
    cfg_vld = 1'b0;
    chk("cfg_rdy_in_drain", 64'(cfg_rdy), 64'd0);
    drain(1'b0, 8);

    // Zero counts behave as one pass, one pixel.
    send_cfg(0, 0);
    push4(4, 3, 2, 1);
    send_beat(pk(4, 3, 2, 1), 1'b1);
    drain(1'b0, 4);

    // Reset part way through a drain abandons the tile.
    send_cfg(1, 2);
    push4(11, 12, 13, 14);
    push4(15, 16, 17, 18);
    send_beat(pk(11, 12, 13, 14), 1'b0);
    send_beat(pk(15, 16, 17, 18), 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("words_before_rst", 64'(exp_q.size()), 64'd6);
    ofmap_rdy = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ofmap_vld", 64'(ofmap_vld), 64'd0);
    chk("midrst_cfg_rdy", 64'(cfg_rdy), 64'd1);
    chk("midrst_psum_rdy", 64'(psum_rdy), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    ofmap_rdy = 1'b1;

    // Fresh tile with a lane summing to -7 and a negative MSB lane.
`ifdef OFMAP_RELU_EN
    push4(32'd0, 32'd9, 32'd0, 32'd0);
`else
    push4(32'hFFFF_FFF9, 32'd9, 32'd0, 32'h8000_0000);
`endif
    send_cfg(2, 1);
    send_beat(pk(32'hFFFF_FFFD, 4, 1, 32'h4000_0000), 1'b0);
    send_beat(pk(32'hFFFF_FFFC, 5, 32'hFFFF_FFFF, 32'h4000_0000), 1'b1);
    drain(1'b0, 4);

    // Pixel count above the bank depth clamps to MAX_PIXELS.
    send_cfg(1, 100);
    for (int k = 0; k < int'(MP * AW); k++) begin
      exp_q.push_back(W'(k));
    end
    for (int p = 0; p < int'(MP); p++) begin
      send_beat(pk(W'(4 * p), W'(4 * p + 1), W'(4 * p + 2), W'(4 * p + 3)), p == int'(MP) - 1);
    end
    drain(1'b0, int'(MP * AW));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
